i2c_accel_sequencer: RTL

I2C_ACCEL_SEQUENCER -- requirements
Module: i2c_accel_sequencer

---
 rtl/i2c_accel_sequencer_pkg.sv | 46 ++++
 rtl/i2c_accel_sequencer_timer.sv | 47 ++++
 rtl/i2c_accel_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_accel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_accel_sequencer_pkg
// Purpose  : Shared definitions for the accelerometer I2C sequencer. Holds the
//            byte-engine command encodings, the accelerometer register
//            constants, the step bounds of each command sequence, the FSM
//            state type and the command record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_accel_sequencer_pkg;

  // Byte-level engine command encodings
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  // Accelerometer registers and configuration values
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] VAL_DATA_FORMAT = 8'h02;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] VAL_POWER_CTL   = 8'h08;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  // Step bounds of the command sequences
  localparam logic [4:0] INIT_MID_STOP  = 5'd4;
  localparam logic [4:0] INIT_LAST_STEP = 5'd9;
  localparam logic [4:0] READ_LAST_STEP = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT       = 3'd1,
    ST_WAIT_TICK  = 3'd2,
    ST_READ_BURST = 3'd3,
    ST_ABORT      = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       nack;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/i2c_accel_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_poll_timer
// Purpose  : POLL_DIV down-counter. A start pulse loads POLL_DIV-1; expired is
//            high in the POLL_DIV-th cycle after the start edge, so a consumer
//            that acts on expired leaves its wait state exactly POLL_DIV
//            cycles after entering it.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - (re)load the counter
//            expired       - count has reached zero
// Revision : 1.0 - initial release
// ============================================================================
module i2c_poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int CW = $clog2(POLL_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(POLL_DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0) && !start;

endmodule
`default_nettype wire

// File: rtl/i2c_accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_accel_sequencer
// Purpose  : Drives a byte-level I2C engine to configure a 3-axis
//            accelerometer and then poll its six data registers every
//            POLL_DIV cycles. Write NACKs abort the transaction with a STOP.
// Ports    : clk, rst                       - clock, sync active-high reset
//            enable                         - run init then polling
//            cmd_valid/ready/op/data/nack   - command to the byte engine
//            rsp_valid/data/ack             - engine completion
//            axis_x/y/z, sample_valid       - latest sample and update pulse
//            init_done, nack_err, err_count - status
// Revision : 1.0 - initial release
// ============================================================================
module i2c_accel_sequencer
  import i2c_accel_sequencer_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1D,
  parameter int         POLL_DIV   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_ack,
  output logic [15:0] axis_x,
  output logic [15:0] axis_y,
  output logic [15:0] axis_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        nack_err,
  output logic [7:0]  err_count
);

  localparam logic [7:0] ADDR_WR = {SLAVE_ADDR, 1'b0};
  localparam logic [7:0] ADDR_RD = {SLAVE_ADDR, 1'b1};

  // Command table: what to present for a given state and step.
  function automatic cmd_t cmd_lookup(input state_e st, input logic [4:0] step);
    cmd_t c;
    c = '{op: OP_STOP, data: 8'h00, nack: 1'b0};
    if (st == ST_INIT) begin
      case (step)
        5'd0, 5'd5: c.op = OP_START;
        5'd1, 5'd6: begin c.op = OP_WRITE; c.data = ADDR_WR;         end
        5'd2:       begin c.op = OP_WRITE; c.data = REG_DATA_FORMAT; end
        5'd3:       begin c.op = OP_WRITE; c.data = VAL_DATA_FORMAT; end
        5'd7:       begin c.op = OP_WRITE; c.data = REG_POWER_CTL;   end
        5'd8:       begin c.op = OP_WRITE; c.data = VAL_POWER_CTL;   end
        default:    c.op = OP_STOP;
      endcase
    end else if (st == ST_READ_BURST) begin
      case (step)
        5'd0, 5'd3: c.op = OP_START;
        5'd1:       begin c.op = OP_WRITE; c.data = ADDR_WR;    end
        5'd2:       begin c.op = OP_WRITE; c.data = REG_DATAX0; end
        5'd4:       begin c.op = OP_WRITE; c.data = ADDR_RD;    end
        5'd5, 5'd6, 5'd7, 5'd8, 5'd9: c.op = OP_READ;
        5'd10:      begin c.op = OP_READ; c.nack = 1'b1; end
        default:    c.op = OP_STOP;
      endcase
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic        busy_q, busy_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_op_q, cmd_op_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic        cmd_nack_q, cmd_nack_d;
  logic [47:0] shadow_q, shadow_d;
  logic [15:0] axis_x_q, axis_x_d;
  logic [15:0] axis_y_q, axis_y_d;
  logic [15:0] axis_z_q, axis_z_d;
  logic        sample_valid_q, sample_valid_d;
  logic        init_done_q, init_done_d;
  logic        nack_err_q, nack_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        timer_start;
  logic        timer_expired;
  logic        issue;
  logic        rsp_done;
  logic [4:0]  last_step;
  cmd_t        nxt;

  i2c_poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .expired (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    busy_d         = busy_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_op_d       = cmd_op_q;
    cmd_data_d     = cmd_data_q;
    cmd_nack_d     = cmd_nack_q;
    shadow_d       = shadow_q;
    axis_x_d       = axis_x_q;
    axis_y_d       = axis_y_q;
    axis_z_d       = axis_z_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    nack_err_d     = 1'b0;
    err_count_d    = err_count_q;
    timer_start    = 1'b0;
    issue          = 1'b0;
    nxt            = '0;
    rsp_done       = busy_q && rsp_valid;
    last_step      = (state_q == ST_INIT) ? INIT_LAST_STEP : READ_LAST_STEP;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      busy_d      = 1'b1;
    end
    if (rsp_done) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (init_done_q) begin
            state_d     = ST_WAIT_TICK;
            timer_start = 1'b1;
          end else begin
            state_d = ST_INIT;
            step_d  = 5'd0;
            issue   = 1'b1;
          end
        end
      end

      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_READ_BURST;
          step_d  = 5'd0;
          issue   = 1'b1;
        end
      end

      ST_INIT, ST_READ_BURST: begin
        if (rsp_done) begin
          if (cmd_op_q == OP_WRITE && !rsp_ack) begin
            nack_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
            state_d = ST_ABORT;
            step_d  = 5'd0;
            issue   = 1'b1;
          end else begin
            // Bytes shift in from the top, so after six reads the first
            // byte (X_L) sits in the lowest byte lane.
            if (cmd_op_q == OP_READ) begin
              shadow_d = {rsp_data, shadow_q[47:8]};
            end
            if (step_q == last_step) begin
              step_d = 5'd0;
              if (state_q == ST_INIT) begin
                init_done_d = 1'b1;
              end else begin
                axis_x_d       = shadow_q[15:0];
                axis_y_d       = shadow_q[31:16];
                axis_z_d       = shadow_q[47:32];
                sample_valid_d = 1'b1;
              end
              if (enable) begin
                state_d     = ST_WAIT_TICK;
                timer_start = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_INIT && step_q == INIT_MID_STOP && !enable) begin
              // First config transaction closed with STOP; stop here.
              step_d  = 5'd0;
              state_d = ST_IDLE;
            end else begin
              step_d = step_q + 5'd1;
              issue  = 1'b1;
            end
          end
        end
      end

      ST_ABORT: begin
        // Step 0: STOP outstanding. Step 1: backoff before retrying init.
        if (step_q == 5'd0) begin
          if (rsp_done) begin
            if (!enable) begin
              state_d = ST_IDLE;
            end else if (init_done_q) begin
              state_d     = ST_WAIT_TICK;
              timer_start = 1'b1;
            end else begin
              step_d      = 5'd1;
              timer_start = 1'b1;
            end
          end
        end else begin
          if (!enable) begin
            state_d = ST_IDLE;
            step_d  = 5'd0;
          end else if (timer_expired) begin
            state_d = ST_INIT;
            step_d  = 5'd0;
            issue   = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = 5'd0;
      end
    endcase

    if (issue) begin
      nxt         = cmd_lookup(state_d, step_d);
      cmd_valid_d = 1'b1;
      cmd_op_d    = nxt.op;
      cmd_data_d  = nxt.data;
      cmd_nack_d  = nxt.nack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      step_q         <= 5'd0;
      busy_q         <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_op_q       <= 2'd0;
      cmd_data_q     <= 8'd0;
      cmd_nack_q     <= 1'b0;
      shadow_q       <= '0;
      axis_x_q       <= 16'd0;
      axis_y_q       <= 16'd0;
      axis_z_q       <= 16'd0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      nack_err_q     <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      busy_q         <= busy_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_op_q       <= cmd_op_d;
      cmd_data_q     <= cmd_data_d;
      cmd_nack_q     <= cmd_nack_d;
      shadow_q       <= shadow_d;
      axis_x_q       <= axis_x_d;
      axis_y_q       <= axis_y_d;
      axis_z_q       <= axis_z_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      nack_err_q     <= nack_err_d;
      err_count_q    <= err_count_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_data     = cmd_data_q;
  assign cmd_nack     = cmd_nack_q;
  assign axis_x       = axis_x_q;
  assign axis_y       = axis_y_q;
  assign axis_z       = axis_z_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign nack_err     = nack_err_q;
  assign err_count    = err_count_q;

endmodule
`default_nettype wire
